// File: rtl/maze_port_arbiter.sv
// Round-robin arbiter sharing one maze memory port between two solver engines.
// One access per cycle, reads answered on the owning port three cycles after grant.
module maze_port_arbiter #(
  parameter int maze_width = 6,
  parameter int maze_size  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [maze_width-1:0] req0_row,
  input  logic [maze_width-1:0] req0_col,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [maze_width-1:0] req1_row,
  input  logic [maze_width-1:0] req1_col,
  output logic                  req0_gnt,
  output logic                  req1_gnt,
  output logic                  rsp0_valid,
  output logic                  rsp0_data,
  output logic                  rsp1_valid,
  output logic                  rsp1_data,
  output logic [maze_width-1:0] row,
  output logic [maze_width-1:0] col,
  output logic                  maze_oe,
  output logic                  maze_we,
  input  logic                  maze_in
);

  logic                  last_q, last_d;
  logic [maze_width-1:0] row_q, row_d, col_q, col_d;
  logic                  oe_q, oe_d, we_q, we_d;
  logic                  s1_rd_q, s1_rd_d, s1_ill_q, s1_ill_d, s1_port_q, s1_port_d;
  logic                  s2_rd_q, s2_rd_d, s2_ill_q, s2_ill_d, s2_port_q, s2_port_d;
  logic                  rsp0_valid_q, rsp0_valid_d, rsp0_data_q, rsp0_data_d;
  logic                  rsp1_valid_q, rsp1_valid_d, rsp1_data_q, rsp1_data_d;

  logic                  gnt0_s, gnt1_s, any_gnt_s, legal_s, sel_we_s, rsp_data_s;
  logic [maze_width-1:0] sel_row_s, sel_col_s;

  // Grant decision: contention goes to the port that was not granted last.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      gnt0_s = last_q;
      gnt1_s = ~last_q;
    end else begin
      gnt0_s = req0_valid;
      gnt1_s = req1_valid;
    end
  end

  // Next-state for the command, tag pipeline and response registers.
  always_comb begin
    any_gnt_s = gnt0_s | gnt1_s;
    sel_we_s  = gnt1_s ? req1_we  : req0_we;
    sel_row_s = gnt1_s ? req1_row : req0_row;
    sel_col_s = gnt1_s ? req1_col : req0_col;
    legal_s   = (int'(sel_row_s) < maze_size) && (int'(sel_col_s) < maze_size);

    last_d = last_q;
    if (gnt1_s) begin
      last_d = 1'b1;
    end else if (gnt0_s) begin
      last_d = 1'b0;
    end else begin
      last_d = last_q;
    end

    // Out-of-range coordinates never reach the pins; the select lines simply hold.
    row_d = row_q;
    col_d = col_q;
    oe_d  = 1'b0;
    we_d  = 1'b0;
    if (any_gnt_s && legal_s) begin
      row_d = sel_row_s;
      col_d = sel_col_s;
      oe_d  = ~sel_we_s;
      we_d  = sel_we_s;
    end else begin
      row_d = row_q;
      col_d = col_q;
    end

    s1_rd_d   = any_gnt_s & ~sel_we_s;
    s1_ill_d  = ~legal_s;
    s1_port_d = gnt1_s;
    s2_rd_d   = s1_rd_q;
    s2_ill_d  = s1_ill_q;
    s2_port_d = s1_port_q;

    rsp_data_s   = s2_ill_q ? 1'b1 : maze_in;
    rsp0_valid_d = s2_rd_q & ~s2_port_q;
    rsp1_valid_d = s2_rd_q & s2_port_q;
    rsp0_data_d  = rsp0_valid_d ? rsp_data_s : rsp0_data_q;
    rsp1_data_d  = rsp1_valid_d ? rsp_data_s : rsp1_data_q;
  end

  // State registers; reset discards every access still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= 1'b1;
      row_q        <= '0;
      col_q        <= '0;
      oe_q         <= 1'b0;
      we_q         <= 1'b0;
      s1_rd_q      <= 1'b0;
      s1_ill_q     <= 1'b0;
      s1_port_q    <= 1'b0;
      s2_rd_q      <= 1'b0;
      s2_ill_q     <= 1'b0;
      s2_port_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= 1'b0;
    end else begin
      last_q       <= last_d;
      row_q        <= row_d;
      col_q        <= col_d;
      oe_q         <= oe_d;
      we_q         <= we_d;
      s1_rd_q      <= s1_rd_d;
      s1_ill_q     <= s1_ill_d;
      s1_port_q    <= s1_port_d;
      s2_rd_q      <= s2_rd_d;
      s2_ill_q     <= s2_ill_d;
      s2_port_q    <= s2_port_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign req0_gnt   = gnt0_s;
  assign req1_gnt   = gnt1_s;
  assign row        = row_q;
  assign col        = col_q;
  assign maze_oe    = oe_q;
  assign maze_we    = we_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_data  = rsp1_data_q;

endmodule
